// File: rtl/soc_mem_pkg.sv
`default_nettype none
// soc_mem_pkg -- shared MMIO map, STATUS bit indices and byte-lane merge helper. Rev 1.0
package soc_mem_pkg;

  localparam logic [15:0] MMIO_HI_DEFAULT = 16'hBFAF;

  localparam logic [15:0] OFS_LED     = 16'h0000;
  localparam logic [15:0] OFS_COUNT   = 16'h0004;
  localparam logic [15:0] OFS_COMPARE = 16'h0008;
  localparam logic [15:0] OFS_STATUS  = 16'h000C;

  localparam int STATUS_IRQ_BIT = 0;
  localparam int STATUS_ERR_BIT = 1;

  typedef enum logic [1:0] {
    RGN_RAM  = 2'd0,
    RGN_MMIO = 2'd1,
    RGN_NONE = 2'd2
  } region_e;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  lanes);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// mmio_timer -- free-running COUNT, COMPARE register and sticky compare interrupt. Rev 1.0
module mmio_timer
  import soc_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic        wr_status,
  input  logic [31:0] wdata,
  input  logic [3:0]  sel,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        irq
);

  logic [31:0] count_inc;
  logic        match;
  logic        irq_clr;

  assign count_inc = count + 32'd1;
  // Match uses the pre-increment value; the flag appears one cycle later.
  assign match     = (count == compare) && (compare != 32'd0);
  assign irq_clr   = wr_status && sel[0] && wdata[STATUS_IRQ_BIT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= 32'd0;
      compare <= 32'd0;
      irq     <= 1'b0;
    end else begin
      count <= wr_count ? lane_merge(count_inc, wdata, sel) : count_inc;
      if (wr_compare) compare <= lane_merge(compare, wdata, sel);
      if (match)        irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// data_mem_responder -- data-memory port responder: word RAM plus LED/timer/status MMIO window. Rev 1.0
module data_mem_responder
  import soc_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [15:0] MMIO_HI     = MMIO_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  sel,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic        irq,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  region_e     region;
  logic [15:0] offset;
  logic [AW-1:0] idx;
  logic        mmio_we;
  logic        wr_led;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        err_clr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        unused_addr;

  assign unused_addr = &{1'b0, addr[1:0]};
  assign offset      = addr[15:0];
  assign idx         = addr[AW+1:2];

  always_comb begin
    region = RGN_NONE;
    if (addr[31:16] == MMIO_HI)                   region = RGN_MMIO;
    else if ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS)) region = RGN_RAM;
  end

  assign mmio_we    = we && (region == RGN_MMIO);
  assign wr_led     = mmio_we && (offset == OFS_LED);
  assign wr_count   = mmio_we && (offset == OFS_COUNT);
  assign wr_compare = mmio_we && (offset == OFS_COMPARE);
  assign wr_status  = mmio_we && (offset == OFS_STATUS);
  assign err_clr    = wr_status && sel[0] && wdata[STATUS_ERR_BIT];

  // RAM has no reset; gating on rst drops a write that coincides with reset.
  always_ff @(posedge clk) begin
    if (rst && we && (region == RGN_RAM)) mem[idx] <= lane_merge(mem[idx], wdata, sel);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led      <= 16'h0000;
      addr_err <= 1'b0;
    end else begin
      if (wr_led && sel[0]) led[7:0]  <= wdata[7:0];
      if (wr_led && sel[1]) led[15:8] <= wdata[15:8];
      if (we && (region == RGN_NONE)) addr_err <= 1'b1;
      else if (err_clr)               addr_err <= 1'b0;
    end
  end

  mmio_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .wr_count   (wr_count),
    .wr_compare (wr_compare),
    .wr_status  (wr_status),
    .wdata      (wdata),
    .sel        (sel),
    .count      (count),
    .compare    (compare),
    .irq        (irq)
  );

  always_comb begin
    rdata = 32'd0;
    case (region)
      RGN_RAM: rdata = mem[idx];
      RGN_MMIO: begin
        case (offset)
          OFS_LED:     rdata = {16'd0, led};
          OFS_COUNT:   rdata = count;
          OFS_COMPARE: rdata = compare;
          OFS_STATUS:  rdata = {30'd0, addr_err, irq};
          default:     rdata = 32'd0;
        endcase
      end
      default: rdata = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// tb_data_mem_responder -- directed self-checking bench for data_mem_responder. Rev 1.0
module tb_data_mem_responder;

  localparam logic [31:0] A_LED     = 32'hBFAF_0000;
  localparam logic [31:0] A_COUNT   = 32'hBFAF_0004;
  localparam logic [31:0] A_COMPARE = 32'hBFAF_0008;
  localparam logic [31:0] A_STATUS  = 32'hBFAF_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] rdata;
  logic [15:0] led;
  logic        irq;
  logic        addr_err;

  int total = 0;
  int bad = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .MMIO_HI(16'hBFAF)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .sel      (sel),
    .rdata    (rdata),
    .led      (led),
    .irq      (irq),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single-cycle write; returns 1 time unit after the committing edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    we = 1'b1; addr = a; wdata = d; sel = s;
    @(posedge clk); #1;
    we = 1'b0; sel = 4'd0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a; #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    // Reset
    #1 rst = 1'b0;
    #2;
    check("rst_led", {16'd0, led}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_err", {31'd0, addr_err}, 32'd0);
    do_read("rst_count", A_COUNT, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    addr = A_COUNT;
    repeat (5) @(posedge clk); #1;
    check("count_after_release", rdata, 32'd5);

    // Byte lanes
    do_write(32'h40, 32'h1122_3344, 4'b1111);
    do_write(32'h40, 32'hAAAA_AAAA, 4'b0100);
    do_read("lane_merge", 32'h40, 32'h11AA_3344);
    do_write(32'h40, 32'hFFFF_FFFF, 4'b0000);
    do_read("sel_zero", 32'h40, 32'h11AA_3344);

    // Read during write
    do_write(32'h80, 32'h0123_4567, 4'b1111);
    we = 1'b1; addr = 32'h80; wdata = 32'hDEAD_BEEF; sel = 4'b1111;
    #1 check("rdw_old", rdata, 32'h0123_4567);
    @(posedge clk); #1;
    we = 1'b0; sel = 4'd0;
    check("rdw_new", rdata, 32'hDEAD_BEEF);

    // Timer compare
    do_write(A_COMPARE, 32'd20, 4'b1111);
    do_write(A_COUNT, 32'd10, 4'b1111);
    do_read("count_loaded", A_COUNT, 32'd10);
    repeat (10) @(posedge clk); #1;
    check("count_at_20", rdata, 32'd20);
    check("irq_before", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq_rise", {31'd0, irq}, 32'd1);
    check("count_21", rdata, 32'd21);
    do_write(A_STATUS, 32'h1, 4'b0001);
    check("irq_clear", {31'd0, irq}, 32'd0);
    do_write(A_COUNT, 32'd20, 4'b1111);
    do_write(A_STATUS, 32'h1, 4'b0001);
    check("irq_set_wins", {31'd0, irq}, 32'd1);
    do_write(A_STATUS, 32'h1, 4'b0001);
    check("irq_clear2", {31'd0, irq}, 32'd0);
    do_write(A_COMPARE, 32'd0, 4'b1111);
    do_write(A_COUNT, 32'd0, 4'b1111);
    repeat (3) @(posedge clk); #1;
    check("compare_zero_no_irq", {31'd0, irq}, 32'd0);
    do_write(A_COUNT, 32'hFFFF_FFFF, 4'b1111);
    do_read("count_max", A_COUNT, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    check("count_wrap", rdata, 32'd0);
    do_write(A_COUNT, 32'h0000_0100, 4'b1111);
    do_write(A_COUNT, 32'hAB00_0000, 4'b1000);
    do_read("count_partial", A_COUNT, 32'hAB00_0101);

    // LED
    do_write(A_LED, 32'h1234_5678, 4'b0011);
    check("led_write", {16'd0, led}, 32'h0000_5678);
    do_write(A_LED, 32'hFFFF_AAFF, 4'b0010);
    do_read("led_read", A_LED, 32'h0000_AA78);
    do_write(32'hBFAF_0010, 32'h1234_5678, 4'b1111);
    do_read("mmio_hole", 32'hBFAF_0010, 32'd0);
    check("mmio_hole_no_err", {31'd0, addr_err}, 32'd0);

    // Unmapped
    do_write(32'h0, 32'h0BAD_F00D, 4'b1111);
    do_write(32'hFFC, 32'h5A5A_5A5A, 4'b1111);
    do_write(32'h1000, 32'hFFFF_FFFF, 4'b1111);
    check("unmapped_err", {31'd0, addr_err}, 32'd1);
    do_read("unmapped_read", 32'h1000, 32'd0);
    do_read("ram_word0_kept", 32'h0, 32'h0BAD_F00D);
    do_read("ram_last_kept", 32'hFFC, 32'h5A5A_5A5A);
    do_read("status_err", A_STATUS, 32'h2);
    do_write(A_STATUS, 32'h2, 4'b0001);
    check("err_clear", {31'd0, addr_err}, 32'd0);

    // Async reset mid-run
    do_write(A_LED, 32'h0000_00FF, 4'b0011);
    do_write(A_COMPARE, 32'd50, 4'b1111);
    do_write(A_COUNT, 32'd50, 4'b1111);
    @(posedge clk); #1;
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    check("pre_rst_led", {16'd0, led}, 32'h0000_00FF);
    addr = A_COMPARE;
    #1 rst = 1'b0;
    #1;
    check("async_irq", {31'd0, irq}, 32'd0);
    check("async_led", {16'd0, led}, 32'd0);
    check("async_compare", rdata, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the CPU data-memory port: accepts the M-stage write strobe, byte-lane select, address and store data the pipeline drives, and returns load data to it. Backs a word-organised data RAM and a small memory-mapped peripheral window (LED register, free-running counter with compare interrupt, error status). Sits beside the `mips` core at SoC top level, wired directly to its `memwriteM`/`aluoutM`/`writedata2M`/`selM`/`readdataM` signals.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit RAM words; power of two; RAM occupies byte addresses 0 .. 4*DEPTH_WORDS-1.
- `MMIO_HI`, 16'hBFAF: value of `addr[31:16]` that selects the MMIO window.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `we`  in  1  write strobe (from `memwriteM`).
- `addr`  in  32  byte address (from `aluoutM`); `addr[1:0]` ignored.
- `wdata`  in  32  store data, already lane-replicated by the core (from `writedata2M`).
- `sel`  in  4  byte-lane enables; bit i gates `wdata[8i+7:8i]` (from `selM`).
- `rdata`  out  32  load data (to `readdataM`).
- `led`  out  16  LED register contents.
- `irq`  out  1  timer interrupt pending.
- `addr_err`  out  1  sticky: a write hit an unmapped address.

## Operation
- Decode: MMIO if `addr[31:16]==MMIO_HI`; else RAM if `addr[31:2] < DEPTH_WORDS`; else unmapped.
- RAM write: when `we`, each lane with `sel[i]=1` updated at the edge; lanes with `sel[i]=0` keep old data. `we` with `sel==0` writes nothing.
- RAM read: full word at `addr[2+log2(DEPTH_WORDS)-1:2]`, `sel` ignored for reads; core does lane extraction/extension.
- MMIO registers (offset = `addr[15:0]`):
  - 0x0000 LED: R/W, low 16 bits; `sel[1:0]` gate its two bytes.
  - 0x0004 COUNT: R/W, increments by 1 every cycle, wraps 0xFFFF_FFFF -> 0; a write replaces the increment that cycle (lanes per `sel`, unselected lanes take the incremented value).
  - 0x0008 COMPARE: R/W, per-lane.
  - 0x000C STATUS: bit0 = irq, bit1 = addr_err, rest read 0; write with `wdata[0]=1` and `sel[0]=1` clears irq; `wdata[1]=1` and `sel[0]=1` clears addr_err.
  - other offsets: read 0, writes dropped.
- irq set in the cycle after COUNT (pre-increment value) equals COMPARE and COMPARE != 0; stays set until cleared. Set and clear in the same cycle: set wins.
- Unmapped: reads return 0; writes dropped and set addr_err (set wins over a simultaneous clear).

## Timing
- Reads combinational: `rdata` valid in the same cycle `addr` is presented (matches single-cycle M stage).
- Writes commit at the rising edge with `we` high; read of the same location in that cycle returns the old value, new value from the next cycle.
- Zero-latency, no handshake, no stall; one access per cycle.
- Reset (`rst`=0, async): LED=0, COUNT=0, COMPARE=0, irq=0, addr_err=0; `rdata` for MMIO reflects these immediately. RAM contents not reset (undefined until written). Reset mid-operation aborts any write in that cycle.
- COUNT resumes incrementing on the first edge after `rst` deasserts.

## Structure
- Shared package `soc_mem_pkg`: MMIO offsets (LED/COUNT/COMPARE/STATUS), `MMIO_HI` default, STATUS bit indices, lane-merge function (old word, new word, sel -> merged).
- One sub-module: `mmio_timer` (COUNT, COMPARE, irq set/clear logic, register write port). RAM array and decode stay in the top.

## Test plan
- Reset: drive `rst`=0 then 1 -> `led`=0, `irq`=0, `addr_err`=0; read 0xBFAF_0004 returns a value equal to cycles since release.
- Byte lanes: write 0x1122_3344 sel=1111 to 0x40, then 0xAAAA_AAAA sel=0100 -> read 0x40 = 0x11AA_3344; sel=0000 write leaves it unchanged.
- Read-during-write: write 0xDEAD_BEEF to 0x80 while reading 0x80 -> old value that cycle, 0xDEAD_BEEF next cycle.
- Timer: COMPARE=20, COUNT=10 -> irq rises the cycle after COUNT reads 20; STATUS write 0x1 clears it; clear coinciding with a match keeps irq=1; COMPARE=0 never fires; COUNT written 0xFFFF_FFFF reads 0 next cycle.
- Unmapped: write to 4*DEPTH_WORDS -> no RAM word changes, `addr_err`=1, read returns 0; STATUS write 0x2 clears it.
- Async reset mid-run: pull `rst` low between edges with irq=1, LED=0x00FF -> both 0 immediately without a clock edge.
